// File: rtl/gray_pkg.sv
// Shared constants and helpers for the binary/Gray counter family.
// bin2gray works on a fixed maximum width; callers zero-extend and slice.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 64;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Upper zero bits stay zero, so truncating the result gives the narrow Gray code.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter: XOR-prefix chain from the MSB down.
// Kept standalone so other blocks can reuse it.
module gray2bin_n
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic [WIDTH-1:0] v_bin;
        v_bin            = {WIDTH{1'b0}};
        v_bin[WIDTH-1]   = i_gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            v_bin[i] = v_bin[i+1] ^ i_gray[i];
        end
        o_bin = v_bin;
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding a registered binary count, its registered Gray code
// and a one-cycle wrap pulse; loads accept binary or Gray values.
module gray_counter
    import gray_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] g,
    output logic             wrap
);

    localparam logic [MAX_WIDTH-1:0] RST_G_FULL = bin2gray(MAX_WIDTH'(RST_VAL));
    localparam logic [WIDTH-1:0]     RST_G      = RST_G_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0]     ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]     ALL_ZEROS  = {WIDTH{1'b0}};

    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_g;
    logic                 r_wrap;

    logic [WIDTH-1:0]     w_ld_bin;
    logic [WIDTH-1:0]     w_ld_sel;
    logic [WIDTH-1:0]     w_nxt_b;
    logic [WIDTH-1:0]     w_nxt_g;
    logic [MAX_WIDTH-1:0] w_nxt_g_full;
    logic                 w_nxt_wrap;

    gray2bin_n #(
        .WIDTH (WIDTH)
    ) u_ld_g2b (
        .i_gray (ld_val),
        .o_bin  (w_ld_bin)
    );

    assign w_ld_sel = load_is_gray ? w_ld_bin : ld_val;

    // Next binary value and wrap flag; load beats count, count beats hold.
    always_comb begin
        w_nxt_b    = r_b;
        w_nxt_wrap = 1'b0;
        if (load) begin
            w_nxt_b    = w_ld_sel;
            w_nxt_wrap = 1'b0;
        end else if (en) begin
            if (dir == DIR_DN) begin
                w_nxt_b    = r_b - ONE;
                w_nxt_wrap = (r_b == ALL_ZEROS);
            end else begin
                w_nxt_b    = r_b + ONE;
                w_nxt_wrap = (r_b == ALL_ONES);
            end
        end else begin
            w_nxt_b    = r_b;
            w_nxt_wrap = 1'b0;
        end
    end

    assign w_nxt_g_full = bin2gray(MAX_WIDTH'(w_nxt_b));
    assign w_nxt_g      = w_nxt_g_full[WIDTH-1:0];

    // State registers; g is always derived from the same next binary value as b.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b    <= RST_VAL;
            r_g    <= RST_G;
            r_wrap <= 1'b0;
        end else begin
            r_b    <= w_nxt_b;
            r_g    <= w_nxt_g;
            r_wrap <= w_nxt_wrap;
        end
    end

    assign b    = r_b;
    assign g    = r_g;
    assign wrap = r_wrap;

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised binary/Gray up/down counter with synchronous load. Holds a registered binary count and its registered Gray-code equivalent, and accepts a load value in either binary or Gray form. It extends the team's combinational 4-bit binary-to-Gray converter to arbitrary width, adds the Gray-to-binary direction, and adds registered state. It is used wherever a single-bit-change sequence is needed, such as pointer generation or encoder emulation, and as a standalone lab block.

## Interface
- WIDTH, 4, count width in bits; legal range WIDTH >= 2
- RST_VAL, 0, binary value loaded on reset; must be < 2**WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable
- dir  in  1  count direction: 0 = up (+1), 1 = down (-1)
- load  in  1  synchronous load strobe
- load_is_gray  in  1  1 = ld_val is Gray-coded; 0 = ld_val is binary
- ld_val  in  WIDTH  load value
- b  out  WIDTH  registered binary count
- g  out  WIDTH  registered Gray code of b
- wrap  out  1  registered single-cycle pulse on modular wrap

## Operation
- Priority per rising edge is rst > load > en > hold.
- **rst=1:**
  - b <= RST_VAL
  - g <= bin2gray(RST_VAL)
  - wrap <= 0
  - All other inputs are ignored.
- **load=1:**
  - b <= (load_is_gray ? gray2bin(ld_val) : ld_val)
  - g <= bin2gray(new b)
  - wrap <= 0
  - en and dir are ignored.
- **en=1, dir=0:**
  - b <= b + 1 mod 2**WIDTH
  - wrap <= (b == all ones)
- **en=1, dir=1:**
  - b <= b - 1 mod 2**WIDTH
  - wrap <= (b == 0)
- **Otherwise:** b and g hold, and wrap <= 0.
- Conversion rules:
  - bin2gray(x) = x ^ (x >> 1), so g[W-1] = b[W-1] and g[i] = b[i+1] ^ b[i].
  - gray2bin(y) gives b[W-1] = y[W-1] and b[i] = b[i+1] ^ y[i], computed MSB to LSB.
- Required invariant on every cycle after the first edge following reset: g == bin2gray(b).
- Every count step changes exactly one bit of g. Loads may change any number of bits.
- The direction may reverse on any cycle with no penalty, and the next step uses the new dir.
- Asserting reset mid-count or mid-load discards the pending operation. Outputs equal reset values after that edge.

## Timing
- Latency is 1 cycle for all paths. An input sampled at edge N is visible on b, g and wrap after edge N.
- No combinational path from any input to any output. All outputs come straight from flops.
- wrap stays high for exactly one cycle per wrapping step. It goes high again on the next wrap, so a sustained count with WIDTH=4 pulses it every 16 cycles.
- Outputs before the first reset edge are undefined. The bench must apply rst for at least 1 cycle.

## Structure
- Package gray_pkg holds:
  - the default WIDTH constant
  - the enumerated direction constants DIR_UP = 1'b0 and DIR_DN = 1'b1
  - a bin2gray function
- One sub-module, gray2bin_n #(WIDTH). It is a combinational XOR-prefix chain, instantiated once on the ld_val path. It is kept separate so later blocks can reuse it.
- Next state is computed combinationally. b, g and wrap are held in a single clocked always block with synchronous rst.

## Test plan
All scenarios use WIDTH=4 and RST_VAL=0.
- **Reset:** rst=1 for 2 cycles → b=0000, g=0000, wrap=0. Repeat with RST_VAL=5 → b=0101, g=0111.
- **Up-count:** en=1, dir=0 for 17 cycles from 0. g must follow 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000. wrap=1 only on the 1000→0000 step, and each step changes exactly one g bit.
- **Down-count wrap:** from b=0000 with en=1, dir=1 → b=1111, g=1000, wrap=1. The next step gives b=1110, g=1001, wrap=0.
- **Load formats:**
  - load=1, load_is_gray=1, ld_val=1101 → b=1001, g=1101.
  - load_is_gray=0, ld_val=1101 → b=1101, g=1011.
- **Priority:**
  - load=1 with en=1 and ld_val=0011 (binary) → b=0011, no increment.
  - rst=1 with load=1 → b=0000.
  - load of 1111 followed by an up-step → wrap=1 on the step only.
- **Hold and reversal:**
  - en=0 for 5 cycles while dir toggles → b, g unchanged and wrap=0.
  - Then alternate dir each cycle with en=1 → b oscillates 0110↔0111 (starting from b=0110) while g keeps single-bit changes.
